// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, divisor tables for the 50 MHz clock,
// receiver FSM states and the oversample/majority sample positions.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam logic [3:0] SMP_A   = 4'd6;
  localparam logic [3:0] SMP_B   = 4'd7;
  localparam logic [3:0] SMP_C   = 4'd8;
  localparam logic [3:0] OS_LAST = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // 16x oversample divisor: one tick every div+1 clocks.
  function automatic logic [15:0] os_div(input logic [2:0] baud);
    case (baud)
      BAUD_19200:  os_div = 16'd162;
      BAUD_38400:  os_div = 16'd80;
      BAUD_57600:  os_div = 16'd53;
      BAUD_115200: os_div = 16'd26;
      default:     os_div = 16'd324;
    endcase
  endfunction

  // 1x bit divisor used by the byte transmitter.
  function automatic logic [15:0] tx_div(input logic [2:0] baud);
    case (baud)
      BAUD_19200:  tx_div = 16'd2603;
      BAUD_38400:  tx_div = 16'd1301;
      BAUD_57600:  tx_div = 16'd867;
      BAUD_115200: tx_div = 16'd433;
      default:     tx_div = 16'd5207;
    endcase
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: latches the divisor on clear and emits a
// one-clock tick every div+1 clocks while enabled.
module uart_os_tick
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [2:0] baud_set_i,
  output logic       tick_o
);

  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_q);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      div_d = os_div(baud_set_i);
      cnt_d = '0;
    end else if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= os_div(BAUD_9600);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with 16x oversampling and 2-of-3 majority voting
// around mid-bit; returns to idle mid stop bit to tolerate fast senders.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned OS_RATE  = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] Baud_Set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       uart_state
);

  // The divisor table is built for a 50 MHz clock and 16x oversampling only.
  if (OS_RATE != 16 || CLK_FREQ == 0) begin : gen_cfg_err
    $error("uart_byte_rx: only OS_RATE=16 is supported");
  end

  logic       sync1_q, sync2_q, hist_q;
  rx_state_e  state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       smp_a_q, smp_a_d;
  logic       smp_b_q, smp_b_d;
  logic       rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d;

  logic os_tick;
  logic start_go;
  logic decide;
  logic wrap;
  logic maj;

  // History flop must be high, so a line held low cannot re-trigger.
  assign start_go = (state_q == StIdle) && hist_q && !sync2_q;
  assign decide   = os_tick && (os_cnt_q == SMP_C);
  assign wrap     = os_tick && (os_cnt_q == OS_LAST);
  assign maj      = (smp_a_q & smp_b_q) | (smp_a_q & sync2_q) | (smp_b_q & sync2_q);

  uart_os_tick u_os_tick (
    .clk_i      (Clk),
    .rst_ni     (Rst_n),
    .clr_i      (start_go),
    .en_i       (state_q != StIdle),
    .baud_set_i (Baud_Set),
    .tick_o     (os_tick)
  );

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    smp_a_d     = smp_a_q;
    smp_b_d     = smp_b_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (os_tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
      if (os_cnt_q == SMP_A) smp_a_d = sync2_q;
      if (os_cnt_q == SMP_B) smp_b_d = sync2_q;
    end

    unique case (state_q)
      StIdle: begin
        os_cnt_d  = '0;
        bit_idx_d = '0;
        if (start_go) state_d = StStart;
      end
      StStart: begin
        if (decide && maj) begin
          state_d  = StIdle;
          os_cnt_d = '0;
        end else if (wrap) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (decide) shift_d[bit_idx_q] = maj;
        if (wrap) begin
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (decide) begin
          if (maj) begin
            data_d    = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d  = StIdle;
          os_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      hist_q      <= 1'b1;
      state_q     <= StIdle;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      smp_a_q     <= 1'b0;
      smp_b_q     <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      hist_q      <= sync2_q;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      smp_a_q     <= smp_a_d;
      smp_b_q     <= smp_b_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_byte  = data_q;
  assign Rx_Done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign uart_state = (state_q != StIdle);

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Receives one 8N1 UART frame from the asynchronous uart_rx line and presents the byte with a one-cycle Rx_Done strobe. It is the receive-side partner of the byte transmitter in the UART2I2C bridge and feeds received command bytes to the I2C sequencing logic. It uses 16x oversampling with 3-sample majority voting and the same Baud_Set encoding as the transmitter, at Clk = 50 MHz.

Parameters:
CLK_FREQ, 50000000, Clk frequency in Hz; documentation only, because the divisor table is fixed for 50 MHz.
OS_RATE, 16, oversample ticks per bit; fixed, not to be overridden.

Ports:
Clk  input  1  system clock
Rst_n  input  1  synchronous active-low reset, sampled on posedge Clk
Baud_Set  input  3  0=9600, 1=19200, 2=38400, 3=57600, 4=115200, others=9600
uart_rx  input  1  asynchronous serial line, idle high
data_byte  output  8  last correctly received byte, LSB first on the line
Rx_Done  output  1  one-Clk pulse when data_byte is updated
frame_err  output  1  one-Clk pulse when the stop bit samples low
uart_state  output  1  high from start-edge detect until return to IDLE

Behaviour:
- Interface (already decided): one clock, Clk; reset Rst_n is synchronous and active-low. All flops reset only on posedge Clk with Rst_n=0.
- Reset values: data_byte=0x00, Rx_Done=0, frame_err=0, uart_state=0, state=IDLE, all counters 0, synchronizer flops=1.
- Input conditioning: uart_rx passes through a 2-flop synchronizer plus one history flop. A start edge is the history flop at 1 and the synced flop at 0, so a line stuck low never re-triggers.
- Divisor table (oversample tick every div+1 Clks): 324, 162, 80, 53, 26 for Baud_Set 0..4; default 324.
- The divisor is latched on start-edge detect. A Baud_Set change mid-frame takes effect on the next frame only.
- Tick generator: div_cnt is 16 bits. It clears on start-edge detect and counts 0..div. An os tick fires when div_cnt==div, and div_cnt then wraps to 0. os_cnt is 4 bits and increments on each os tick, wrapping 15->0 at the bit boundary.
- Sampling: the synced line is sampled on the os ticks where os_cnt is 6, 7 and 8. The bit value is the 2-of-3 majority, evaluated on the os_cnt==8 tick.
- FSM states and transitions:
  - IDLE: on start edge -> START, uart_state<=1.
  - START: if the majority is 1 (false start/glitch) -> IDLE, uart_state<=0, no strobes. If it is 0, continue to the os_cnt 15->0 wrap -> DATA, bit_idx=0.
  - DATA: shift the majority into shift_reg[bit_idx]. At the wrap after bit_idx==7 -> STOP; otherwise bit_idx++.
  - STOP: on the os_cnt==8 decision:
    - majority 1: data_byte<=shift_reg, Rx_Done<=1 for one Clk.
    - majority 0: frame_err<=1 for one Clk, data_byte unchanged.
    - Either way -> IDLE, uart_state<=0, in the same cycle.
- Early return to IDLE mid stop bit allows back-to-back frames at up to about 3% sender-fast mismatch.
- Latency: Rx_Done is registered and asserts one Clk after the stop-bit decision tick.
- Rx_Done and frame_err are mutually exclusive and never assert outside the STOP decision.
- Reset mid-frame: the next edge returns the block to IDLE with outputs at reset values; the partial byte is discarded.
- A start edge arriving while not in IDLE is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - Baud_Set codes and the 16x divisor table function (the transmitter's 1x table lives alongside it);
  - FSM state enum (IDLE, START, DATA, STOP);
  - sample constants SMP_A=6, SMP_B=7, SMP_C=8;
  - constant OS_LAST=15.
- One natural sub-module is uart_os_tick: it holds the divisor latch, div_cnt and the os tick pulse, and takes a sync clear input. The synchronizer, majority vote and FSM stay in uart_byte_rx.

Test Plan:
- Baud_Set=0, drive 0xA5 with 5208-Clk bits -> data_byte=0xA5, one Rx_Done pulse, uart_state high about 9.5 bit times, frame_err=0.
- Baud_Set=4, send 0x00 then 0xFF back-to-back with a 432-Clk bit period and 1 stop bit -> two Rx_Done pulses, data_byte 0x00 then 0xFF.
- Pulse uart_rx low for 2 os ticks (54 Clks at Baud_Set=4) -> START exits to IDLE, no Rx_Done, no frame_err.
- Send 0x3C with the stop bit forced 0 after a good 0x81 -> frame_err one pulse, data_byte stays 0x81. Holding the line low afterwards produces no further frames until the line returns high.
- Flip the sample at os_cnt=7 in every data bit of 0x5A -> majority yields data_byte=0x5A. At ±2% bit-period skew, 0x5A is also received correctly.
- Assert Rst_n=0 during bit 4 of a frame, release, then send 0x77 -> all outputs at reset values, then data_byte=0x77 with Rx_Done.
